// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl
//
// Purpose:
//   Drives the register file's single write port from two producers. ALU
//   results always win the port. Load results are parked in a small FIFO
//   and drain into cycles the ALU leaves idle. When the FIFO is empty and
//   the ALU is idle, a load bypasses straight to the output stage. A
//   pending-write mask tells issue logic which registers have a write
//   queued or currently on the port.
//
// Optional feature (macro RF_WB_STARVE_GUARD_EN):
//   Defined   : a starve counter tracks consecutive ALU wins while loads
//               wait. After STARVE_LIMIT such wins, alu_ready drops for one
//               cycle so the FIFO head is written.
//   Undefined : alu_ready is tied to 1. Loads can starve under continuous
//               ALU traffic.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   alu_valid/ready    ALU result handshake; alu_tgt, alu_data carry the result
//   mem_valid/ready    load result handshake; mem_tgt, mem_data carry the result
//   TGT, RF_write_data registered write address and write data
//   write_en_reg       registered write enable (one cycle per write)
//   pending_mask       bit i set when a write to register i is queued or on the port
//   fifo_count         load FIFO occupancy
//   order_err          sticky flag: ALU write issued to a register with a pending write
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// valid is ignored while ready is 0, and the producer must hold its data
// until the transfer happens. ready never depends on valid.

module rf_writeback_ctrl #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 3,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alu_valid,
    output logic                        alu_ready,
    input  logic [ADDR_W-1:0]           alu_tgt,
    input  logic [DATA_W-1:0]           alu_data,
    input  logic                        mem_valid,
    output logic                        mem_ready,
    input  logic [ADDR_W-1:0]           mem_tgt,
    input  logic [DATA_W-1:0]           mem_data,
    output logic [ADDR_W-1:0]           TGT,
    output logic [DATA_W-1:0]           RF_write_data,
    output logic                        write_en_reg,
    output logic [2**ADDR_W-1:0]        pending_mask,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        order_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_check
        $error("rf_writeback_ctrl: FIFO_DEPTH must be a power of 2 >= 2, STARVE_LIMIT >= 1");
    end

    logic [ADDR_W-1:0] fifo_tgt  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    logic fifo_full;
    logic fifo_empty;
    logic alu_acc;
    logic mem_acc;
    logic pop;
    logic bypass;
    logic push;

    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign mem_ready  = !fifo_full;

    assign alu_acc = alu_valid && alu_ready;
    assign mem_acc = mem_valid && mem_ready;
    // Port priority: ALU, then queued loads, then a bypassing load.
    assign pop     = !alu_acc && !fifo_empty;
    assign bypass  = !alu_acc && fifo_empty && mem_acc;
    assign push    = mem_acc && !bypass;

    // Starve guard / ALU ready
`ifdef RF_WB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    logic [SC_W-1:0] starve_cnt;
    logic            alu_ready_q;
    logic            starve_inc;
    logic            starve_fire;

    // An ALU win while loads wait is one starved cycle for the FIFO head.
    assign starve_inc  = alu_acc && !fifo_empty;
    assign starve_fire = starve_inc && (starve_cnt == SC_W'(STARVE_LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt  <= '0;
            alu_ready_q <= 1'b1;
        end else begin
            // Dropping ready for one cycle guarantees the FIFO head wins next.
            alu_ready_q <= !starve_fire;
            if (pop || starve_fire) begin
                starve_cnt <= '0;
            end else if (starve_inc) begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end
        end
    end

    assign alu_ready = alu_ready_q;
`else
    assign alu_ready = 1'b1;
`endif

    // Load FIFO storage. Only slots between rd_ptr and rd_ptr+count are ever
    // read, so the storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_tgt[wr_ptr]  <= mem_tgt;
            fifo_data[wr_ptr] <= mem_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Pending-write mask. Slot rd_ptr+i is live when i < count. Pointer
    // arithmetic wraps for free because the depth is a power of 2.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (CNT_W'(i) < fifo_count) begin
                pending_mask[fifo_tgt[rd_ptr + PTR_W'(i)]] = 1'b1;
            end
        end
        if (write_en_reg) begin
            pending_mask[TGT] = 1'b1;
        end
    end

    // Output stage and sticky ordering flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_en_reg  <= 1'b0;
            TGT           <= '0;
            RF_write_data <= '0;
            order_err     <= 1'b0;
        end else begin
            write_en_reg <= alu_acc || pop || bypass;
            if (alu_acc) begin
                TGT           <= alu_tgt;
                RF_write_data <= alu_data;
            end else if (pop) begin
                TGT           <= fifo_tgt[rd_ptr];
                RF_write_data <= fifo_data[rd_ptr];
            end else if (bypass) begin
                TGT           <= mem_tgt;
                RF_write_data <= mem_data;
            end
            // The write still proceeds; the flag only reports the hazard.
            if (alu_acc && pending_mask[alu_tgt]) begin
                order_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/rf_writeback_ctrl.md
Name: rf_writeback_ctrl

Overview:
Write-side driver for the register file. Merges ALU results and load (memory) results into the register file's single write port (TGT / RF_write_data / write_en_reg). ALU results take priority. Load results are buffered in a small FIFO and drain into idle write-port cycles. Also exports a pending-write mask so issue logic can detect hazards against queued writes.

Parameters:
DATA_W, 16, width of write data
ADDR_W, 3, register index width (2**ADDR_W registers)
FIFO_DEPTH, 4, load-result FIFO entries (power of 2, >=2)
STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may be denied before the guard fires (optional feature only)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU result present this cycle
alu_ready  out  1  ALU result accepted when alu_valid && alu_ready
alu_tgt  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load result present
mem_ready  out  1  = !fifo_full; load accepted when mem_valid && mem_ready
mem_tgt  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
TGT  out  ADDR_W  register-file write address (registered)
RF_write_data  out  DATA_W  register-file write data (registered)
write_en_reg  out  1  register-file write enable (registered)
pending_mask  out  2**ADDR_W  bit i=1 if a write to reg i is queued or on the port
fifo_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
order_err  out  1  sticky ordering-violation flag

Behaviour:
- Reset (async, rst=1):
  - Outputs: write_en_reg=0, TGT=0, RF_write_data=0, fifo_count=0, order_err=0, pending_mask=0, alu_ready=1, mem_ready=1.
  - Queued entries are discarded; no write is issued on or after the reset edge.
- Latency: an accepted ALU result appears on TGT/RF_write_data with write_en_reg=1 exactly 1 cycle later, for exactly 1 cycle.
- Port selection each cycle (registered into the output stage):
  - 1. ALU accepted: write the ALU result.
  - 2. Otherwise, FIFO non-empty: pop the head and write it.
  - 3. Otherwise, mem accepted with FIFO empty: bypass directly to the output stage (no FIFO occupancy, 1-cycle latency).
  - 4. Otherwise: write_en_reg=0; TGT and RF_write_data hold their values.
- Load acceptance and FIFO rules:
  - An accepted load is pushed unless it was bypassed.
  - mem_ready depends only on full. No same-cycle push-on-pop when full; mem_ready stays 0 that cycle.
  - Push and pop in the same cycle when not full: count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Ordering is strictly FIFO.
- pending_mask (combinational from state): OR of decode(tgt) over all valid FIFO entries, plus decode(TGT) when write_en_reg=1.
- Ordering rule: upstream must not issue an ALU write to a register whose pending_mask bit is set.
  - Violation (alu accepted && pending_mask[alu_tgt]) sets order_err=1.
  - order_err stays set until reset.
  - The ALU write still proceeds and no entries are dropped.
- alu_valid while alu_ready=0: ignored. The ALU must hold its result.

Optional Feature:
Macro RF_WB_STARVE_GUARD_EN.
- Enabled:
  - Starve counter increments each cycle the FIFO is non-empty and an ALU write wins the port; clears on any FIFO pop or reset.
  - When the counter equals STARVE_LIMIT-1, alu_ready=0 for the next cycle, which forces a FIFO pop. The counter then clears.
  - alu_ready is registered and resets to 1.
- Disabled:
  - alu_ready is tied to 1 and no counter is built.
  - Loads may starve indefinitely under continuous ALU traffic.

Test Plan:
1. alu_valid=1, alu_tgt=3, alu_data=0x1234 for 1 cycle -> next cycle write_en_reg=1, TGT=3, RF_write_data=0x1234; following cycle write_en_reg=0, TGT/data held.
2. Same cycle: ALU (tgt 1, 0xAAAA) and mem (tgt 2, 0x5555) -> cycle+1 writes r1=0xAAAA; cycle+2 writes r2=0x5555; pending_mask[2]=1 on cycles +1 and +2, 0 on +3.
3. alu_valid held high, 5 loads offered back-to-back (guard disabled) -> fifo_count reaches 4, mem_ready=0 on the 5th offer. Drop alu_valid -> 4 writes in FIFO order on consecutive cycles.
4. Guard enabled, STARVE_LIMIT=8, one queued load (tgt 6, 0x0F0F), alu_valid continuous -> alu_ready=0 for exactly 1 cycle after 8 ALU wins; r6=0x0F0F written in that slot; alu_ready returns to 1.
5. Queue load to r5, then ALU to r5 while queued -> order_err=1 and stays 1 through later traffic; both writes still occur (ALU first, then load); cleared only by rst.
6. 3 loads queued, assert rst asynchronously mid-cycle -> write_en_reg, fifo_count, pending_mask go 0 immediately. After release with no inputs: no writes for 10 cycles.
